// File: rtl/pwm_cfg_scheduler_if.sv
// Write-request and active-configuration bundle between the requesters/PWM core and pwm_cfg_scheduler.
`timescale 1ns/1ps
interface pwm_cfg_scheduler_if;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned EW = 16;

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          sync_commit;
  logic          frame_tick;
  logic [EW-1:0] en_out;
  logic [EW-1:0] en_pwm_mode;
  logic [DW-1:0] pwm_duty_cycle;
  logic          pending;
  logic          err_addr;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output sync_commit, frame_tick,
    input  req0_ready, req1_ready,
    input  en_out, en_pwm_mode, pwm_duty_cycle, pending, err_addr
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  sync_commit, frame_tick,
    output req0_ready, req1_ready,
    output en_out, en_pwm_mode, pwm_duty_cycle, pending, err_addr
  );
endinterface

// File: rtl/pwm_cfg_scheduler.sv
// Round-robin write arbiter for the PWM config bank with shadow registers and
// immediate or frame-aligned atomic commit to the active outputs.
`timescale 1ns/1ps
module pwm_cfg_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  DUTY_RESET     = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_cfg_scheduler_if.slave bus
);
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned EW = 16;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [AW-1:0] ADDR_EN_LO   = AW'(0);
  localparam logic [AW-1:0] ADDR_EN_HI   = AW'(1);
  localparam logic [AW-1:0] ADDR_MODE_LO = AW'(2);
  localparam logic [AW-1:0] ADDR_MODE_HI = AW'(3);
  localparam logic [AW-1:0] ADDR_DUTY    = AW'(4);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] sh_en_q, sh_en_d;
  logic [EW-1:0] sh_mode_q, sh_mode_d;
  logic [DW-1:0] sh_duty_q, sh_duty_d;
  logic [EW-1:0] en_out_q, en_out_d;
  logic [EW-1:0] en_mode_q, en_mode_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          err_q, err_d;

  logic          gnt0_c, gnt1_c, acc_c, mapped_c, commit_c;
  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;

  // rr_ptr names the requester preferred on contention; ready is held low in reset.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && (!bus.req1_valid || !rr_ptr_q)) gnt0_c = 1'b1;
      else if (bus.req1_valid)                              gnt1_c = 1'b1;
    end
  end

  assign bus.req0_ready = gnt0_c;
  assign bus.req1_ready = gnt1_c;
  assign acc_c     = gnt0_c | gnt1_c;
  assign wr_addr_c = gnt1_c ? bus.req1_addr : bus.req0_addr;
  assign wr_data_c = gnt1_c ? bus.req1_data : bus.req0_data;
  assign mapped_c  = (wr_addr_c <= ADDR_DUTY);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    sh_en_d   = sh_en_q;
    sh_mode_d = sh_mode_q;
    sh_duty_d = sh_duty_q;
    en_out_d  = en_out_q;
    en_mode_d = en_mode_q;
    duty_d    = duty_q;
    err_d     = acc_c && !mapped_c;
    commit_c  = 1'b0;

    if (acc_c) rr_ptr_d = gnt0_c;

    if (acc_c && mapped_c) begin
      unique case (wr_addr_c)
        ADDR_EN_LO:   sh_en_d[7:0]    = wr_data_c;
        ADDR_EN_HI:   sh_en_d[15:8]   = wr_data_c;
        ADDR_MODE_LO: sh_mode_d[7:0]  = wr_data_c;
        ADDR_MODE_HI: sh_mode_d[15:8] = wr_data_c;
        default:      sh_duty_d       = wr_data_c;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (acc_c && mapped_c) begin
          if (bus.sync_commit) begin
            state_d = PENDING;
            cnt_d   = '0;
          end else begin
            commit_c = 1'b1;
          end
        end
      end
      PENDING: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (bus.frame_tick || !bus.sync_commit || (TO_EN && (cnt_q == TO_LAST))) begin
          commit_c = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Commit takes the post-write shadow so a same-cycle write is never lost.
    if (commit_c) begin
      en_out_d  = sh_en_d;
      en_mode_d = sh_mode_d;
      duty_d    = sh_duty_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      sh_en_q   <= '0;
      sh_mode_q <= '0;
      sh_duty_q <= DUTY_RESET;
      en_out_q  <= '0;
      en_mode_q <= '0;
      duty_q    <= DUTY_RESET;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      sh_en_q   <= sh_en_d;
      sh_mode_q <= sh_mode_d;
      sh_duty_q <= sh_duty_d;
      en_out_q  <= en_out_d;
      en_mode_q <= en_mode_d;
      duty_q    <= duty_d;
      err_q     <= err_d;
    end
  end

  assign bus.en_out         = en_out_q;
  assign bus.en_pwm_mode    = en_mode_q;
  assign bus.pwm_duty_cycle = duty_q;
  assign bus.pending        = (state_q == PENDING);
  assign bus.err_addr       = err_q;
endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Bench for pwm_cfg_scheduler: directed vector table, reset corner sequence,
// and random traffic against a register-array reference model.
`timescale 1ns/1ps
module tb_pwm_cfg_scheduler;
  localparam int unsigned T_CYC  = 8;
  localparam logic [7:0]  D_RST  = 8'h3C;
  localparam int unsigned N_RAND = 600;

  logic clk;
  logic rst_n;
  pwm_cfg_scheduler_if bus();

  pwm_cfg_scheduler #(.TIMEOUT_CYCLES(T_CYC), .DUTY_RESET(D_RST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sync;
    logic        tick;
    logic        v0;
    logic [6:0]  a0;
    logic [7:0]  d0;
    logic        v1;
    logic [6:0]  a1;
    logic [7:0]  d1;
    logic        r0;
    logic        r1;
    logic [15:0] en;
    logic [15:0] mode;
    logic [7:0]  duty;
    logic        pend;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: shadow/active byte arrays indexed by register address.
  logic [7:0] m_sh[5];
  logic [7:0] m_act[5];
  bit         m_pend;
  int         m_cnt;
  int         m_pref;
  bit         m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic sync, input logic tick,
    input logic v0, input logic [6:0] a0, input logic [7:0] d0,
    input logic v1, input logic [6:0] a1, input logic [7:0] d1,
    input logic r0, input logic r1,
    input logic [15:0] en, input logic [15:0] mode, input logic [7:0] duty,
    input logic pend, input logic err);
    vec_t v;
    v.sync = sync; v.tick = tick;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1;
    v.en = en; v.mode = mode; v.duty = duty; v.pend = pend; v.err = err;
    return v;
  endfunction

  task automatic drive(input logic sync, input logic tick,
                       input logic v0, input logic [6:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [6:0] a1, input logic [7:0] d1);
    bus.sync_commit = sync; bus.frame_tick = tick;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  // Called at a negedge: drive, check readies, clock once, check outputs.
  task automatic apply_row(input vec_t v, input string tag);
    drive(v.sync, v.tick, v.v0, v.a0, v.d0, v.v1, v.a1, v.d1);
    #1;
    chk({tag, " req0_ready"}, 32'(bus.req0_ready), 32'(v.r0));
    chk({tag, " req1_ready"}, 32'(bus.req1_ready), 32'(v.r1));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " en_out"},         32'(bus.en_out),         32'(v.en));
    chk({tag, " en_pwm_mode"},    32'(bus.en_pwm_mode),    32'(v.mode));
    chk({tag, " pwm_duty_cycle"}, 32'(bus.pwm_duty_cycle), 32'(v.duty));
    chk({tag, " pending"},        32'(bus.pending),        32'(v.pend));
    chk({tag, " err_addr"},       32'(bus.err_addr),       32'(v.err));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " en_out"},         32'(bus.en_out),         32'h0);
    chk({tag, " en_pwm_mode"},    32'(bus.en_pwm_mode),    32'h0);
    chk({tag, " pwm_duty_cycle"}, 32'(bus.pwm_duty_cycle), 32'(D_RST));
    chk({tag, " pending"},        32'(bus.pending),        32'h0);
    chk({tag, " err_addr"},       32'(bus.err_addr),       32'h0);
    chk({tag, " req0_ready"},     32'(bus.req0_ready),     32'h0);
    chk({tag, " req1_ready"},     32'(bus.req1_ready),     32'h0);
  endtask

  function automatic logic [6:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 8) return 7'(r % 5);
    return 7'($urandom_range(5, 127));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_sh[i]  = (i == 4) ? D_RST : 8'h00;
      m_act[i] = m_sh[i];
    end
    m_pend = 0; m_cnt = 0; m_pref = 0; m_err = 0;
  endtask

  initial begin
    bit         sync, tick, hv0, hv1, er0, er1, acc, mapped;
    logic [6:0] ha0, ha1, a;
    logic [7:0] hd0, hd1, d;

    // Reset state with requests already asserted: ready must stay low.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 7'h04, 8'h99, 1'b1, 7'h00, 8'h99);
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("init_reset");
    drive(1'b0, 1'b0, 1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: immediate, sync, idle tick, unmapped, contention, commit-on-write, timeout.
    vecs.push_back(mk(0,0, 1,7'h04,8'h80, 0,7'h00,8'h00, 1,0, 16'h0000,16'h0000,8'h80, 0,0));
    vecs.push_back(mk(1,0, 1,7'h00,8'h5A, 0,7'h00,8'h00, 1,0, 16'h0000,16'h0000,8'h80, 1,0));
    vecs.push_back(mk(1,0, 1,7'h01,8'hA5, 0,7'h00,8'h00, 1,0, 16'h0000,16'h0000,8'h80, 1,0));
    vecs.push_back(mk(1,1, 0,7'h00,8'h00, 0,7'h00,8'h00, 0,0, 16'hA55A,16'h0000,8'h80, 0,0));
    vecs.push_back(mk(1,1, 0,7'h00,8'h00, 0,7'h00,8'h00, 0,0, 16'hA55A,16'h0000,8'h80, 0,0));
    vecs.push_back(mk(0,0, 0,7'h00,8'h00, 1,7'h10,8'hFF, 0,1, 16'hA55A,16'h0000,8'h80, 0,1));
    vecs.push_back(mk(0,0, 0,7'h00,8'h00, 0,7'h00,8'h00, 0,0, 16'hA55A,16'h0000,8'h80, 0,0));
    vecs.push_back(mk(0,0, 1,7'h04,8'h11, 1,7'h04,8'h22, 1,0, 16'hA55A,16'h0000,8'h11, 0,0));
    vecs.push_back(mk(0,0, 1,7'h04,8'h33, 1,7'h04,8'h22, 0,1, 16'hA55A,16'h0000,8'h22, 0,0));
    vecs.push_back(mk(0,0, 1,7'h04,8'h33, 1,7'h04,8'h44, 1,0, 16'hA55A,16'h0000,8'h33, 0,0));
    vecs.push_back(mk(0,0, 1,7'h04,8'h55, 1,7'h04,8'h44, 0,1, 16'hA55A,16'h0000,8'h44, 0,0));
    vecs.push_back(mk(1,0, 1,7'h04,8'h55, 0,7'h00,8'h00, 1,0, 16'hA55A,16'h0000,8'h44, 1,0));
    vecs.push_back(mk(1,0, 1,7'h03,8'hF0, 0,7'h00,8'h00, 1,0, 16'hA55A,16'h0000,8'h44, 1,0));
    vecs.push_back(mk(1,1, 1,7'h04,8'h66, 0,7'h00,8'h00, 1,0, 16'hA55A,16'hF000,8'h66, 0,0));
    vecs.push_back(mk(1,0, 0,7'h00,8'h00, 1,7'h02,8'h0F, 0,1, 16'hA55A,16'hF000,8'h66, 1,0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1,0, 0,7'h00,8'h00, 0,7'h00,8'h00, 0,0, 16'hA55A,16'hF000,8'h66, 1,0));
    vecs.push_back(mk(1,0, 0,7'h00,8'h00, 0,7'h00,8'h00, 0,0, 16'hA55A,16'hF00F,8'h66, 0,0));
    vecs.push_back(mk(1,0, 1,7'h00,8'h01, 0,7'h00,8'h00, 1,0, 16'hA55A,16'hF00F,8'h66, 1,0));
    vecs.push_back(mk(0,0, 0,7'h00,8'h00, 0,7'h00,8'h00, 0,0, 16'hA501,16'hF00F,8'h66, 0,0));
    vecs.push_back(mk(1,0, 1,7'h05,8'h77, 0,7'h00,8'h00, 1,0, 16'hA501,16'hF00F,8'h66, 0,1));
    vecs.push_back(mk(1,0, 0,7'h00,8'h00, 0,7'h00,8'h00, 0,0, 16'hA501,16'hF00F,8'h66, 0,0));

    foreach (vecs[i]) apply_row(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a pending sync update.
    apply_row(mk(1,0, 1,7'h00,8'hFF, 0,7'h00,8'h00, 1,0, 16'hA501,16'hF00F,8'h66, 1,0), "rst_seq0");
    apply_row(mk(1,0, 1,7'h01,8'h00, 0,7'h00,8'h00, 1,0, 16'hA501,16'hF00F,8'h66, 1,0), "rst_seq1");
    drive(1'b1, 1'b0, 1'b1, 7'h04, 8'hAA, 1'b1, 7'h00, 8'hBB);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0);
    rst_n = 1'b1;
    @(negedge clk);
    apply_row(mk(1,1, 0,7'h00,8'h00, 0,7'h00,8'h00, 0,0, 16'h0000,16'h0000,D_RST, 0,0), "post_rst_tick");

    // Fresh reset, then random protocol-correct traffic against the model.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sync = 0; hv0 = 0; hv1 = 0;
    ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
    for (int c = 0; c < N_RAND; c++) begin
      if (!hv0 && $urandom_range(0, 2) != 0) begin hv0 = 1; ha0 = rand_addr(); hd0 = 8'($urandom); end
      if (!hv1 && $urandom_range(0, 2) != 0) begin hv1 = 1; ha1 = rand_addr(); hd1 = 8'($urandom); end
      if ($urandom_range(0, 15) == 0) sync = !sync;
      tick = ($urandom_range(0, 9) == 0);
      drive(sync, tick, hv0, ha0, hd0, hv1, ha1, hd1);

      er0 = hv0 && (!hv1 || m_pref == 0);
      er1 = hv1 && !er0;
      #1;
      chk($sformatf("rnd%0d req0_ready", c), 32'(bus.req0_ready), 32'(er0));
      chk($sformatf("rnd%0d req1_ready", c), 32'(bus.req1_ready), 32'(er1));

      acc    = er0 || er1;
      a      = er1 ? ha1 : ha0;
      d      = er1 ? hd1 : hd0;
      mapped = acc && (a < 7'd5);
      if (mapped) m_sh[a] = d;
      m_err = acc && !mapped;
      if (m_pend) begin
        if (tick || !sync || (m_cnt == int'(T_CYC) - 1)) begin
          m_act = m_sh; m_pend = 0; m_cnt = 0;
        end else if (m_cnt < 65535) begin
          m_cnt++;
        end
      end else if (mapped) begin
        if (sync) begin m_pend = 1; m_cnt = 0; end
        else m_act = m_sh;
      end
      if (acc) m_pref = er0 ? 1 : 0;

      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rnd%0d en_out", c),         32'(bus.en_out),         32'({m_act[1], m_act[0]}));
      chk($sformatf("rnd%0d en_pwm_mode", c),    32'(bus.en_pwm_mode),    32'({m_act[3], m_act[2]}));
      chk($sformatf("rnd%0d pwm_duty_cycle", c), 32'(bus.pwm_duty_cycle), 32'(m_act[4]));
      chk($sformatf("rnd%0d pending", c),        32'(bus.pending),        32'(m_pend));
      chk($sformatf("rnd%0d err_addr", c),       32'(bus.err_addr),       32'(m_err));
      if (er0) hv0 = 0;
      if (er1) hv1 = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/pwm_cfg_scheduler.md
# pwm_cfg_scheduler

Write arbiter and commit scheduler for the PWM configuration register bank (output enables, PWM-mode enables, duty cycle). It sits between two write requesters, the SPI register interface and an on-chip pattern sequencer, and the PWM core. Accepted writes land in shadow registers. Shadow contents are copied to the active outputs either immediately or atomically at a PWM frame boundary, so the PWM core never sees a half-updated configuration.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: forced-commit timeout in clk cycles while a commit is pending; 0 disables the timeout; range 0..65535.
- DUTY_RESET, 8'h00: reset value of shadow and active duty cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 (SPI) write request.
- req0_addr  in  7  requester 0 register address.
- req0_data  in  8  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid / req1_addr / req1_data / req1_ready: same as requester 0, for requester 1 (sequencer).
- sync_commit  in  1  1 = commit at frame boundary, 0 = immediate.
- frame_tick  in  1  one-cycle pulse at PWM period wrap.
- en_out  out  16  active output enables.
- en_pwm_mode  out  16  active PWM-mode enables.
- pwm_duty_cycle  out  8  active duty cycle.
- pending  out  1  shadow holds uncommitted data.
- err_addr  out  1  one-cycle pulse when an unmapped address is accepted.

## Operation
- Address map:
  - 0x00: en_out[7:0]
  - 0x01: en_out[15:8]
  - 0x02: en_pwm_mode[7:0]
  - 0x03: en_pwm_mode[15:8]
  - 0x04: duty
  - 0x05..0x7F: unmapped
- Handshake: a write is accepted on a rising clk edge where reqN_valid && reqN_ready. Requesters hold valid/addr/data stable until accepted. reqN_ready is combinational from the valids and the round-robin pointer; it never depends on reqN_ready.
- Arbitration: at most one write accepted per cycle.
  - One valid: that requester gets ready.
  - Both valid: the requester not granted last gets ready.
  - rr_ptr updates only on acceptance; reset value favours requester 0.
- Accepted mapped write: updates the addressed shadow byte. Unmapped write: accepted (ready high), no shadow change, err_addr pulses the following cycle.
- FSM, 2 states: IDLE, PENDING.
  - IDLE, sync_commit=1, mapped write accepted -> PENDING. Timeout counter cleared.
  - IDLE, sync_commit=0, mapped write accepted: shadow and active update on the same edge; stay IDLE.
  - PENDING, frame_tick=1: commit (active <= shadow) -> IDLE.
  - PENDING, counter reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0): forced commit -> IDLE.
  - PENDING, sync_commit=0: commit on the next edge -> IDLE.
  - PENDING, further mapped writes: shadow updates; the counter is not restarted.
- Simultaneous write and commit edge: the commit copies the shadow including that cycle's write. Next state is IDLE.
- Unmapped writes never cause IDLE -> PENDING.
- pending = (state == PENDING).
- Timeout counter is 16 bits, increments each cycle in PENDING, saturates, and clears on leaving PENDING.

## Timing
- Reset (asynchronous, any state, mid-pending included):
  - en_out, en_pwm_mode = 0.
  - pwm_duty_cycle and shadow duty = DUTY_RESET; all other shadow bytes = 0.
  - state = IDLE, pending = 0, err_addr = 0, rr_ptr = 0, counter = 0.
  - req0_ready and req1_ready = 0 while rst_n is low.
  - Uncommitted shadow data is discarded.
- Immediate mode: active output changes on the acceptance edge (0 cycles after accept).
- Sync mode: active output changes on the edge where frame_tick is sampled high, or on the timeout edge.
- A frame_tick in IDLE has no effect.
- Throughput: one write per cycle sustained; with both requesters valid, grants alternate.

## Test plan
- Reset: assert rst_n low mid-PENDING with en_out shadow=0x00FF -> all outputs 0, duty=DUTY_RESET, pending=0; a later frame_tick leaves outputs 0.
- Immediate: sync_commit=0, req0 writes 0x04=0x80 -> req0_ready=1 that cycle; pwm_duty_cycle=0x80 after the edge; pending stays 0.
- Sync commit: sync_commit=1, write 0x00=0x5A, then 0x01=0xA5 -> en_out stays 0, pending=1; frame_tick -> en_out=0xA55A in one step, pending=0.
- Contention: both valid continuously with distinct data -> grants alternate 0,1,0,1; the last-accepted value wins in shadow.
- Timeout: TIMEOUT_CYCLES=8, write 0x02=0x0F with no frame_tick -> en_pwm_mode=0x000F exactly 8 cycles after PENDING entry.
- Edge cases:
  - Write 0x10=0xFF -> accepted, err_addr pulses once, no pending.
  - Write 0x04=0x33 on the frame_tick edge while PENDING -> duty=0x33 after that edge.
